// File: rtl/tetris_pkg.sv
// Shared piece definitions for the next-piece queue and preview renderer.
// Holds the tetromino mask table, piece type width and LFSR taps.
package tetris_pkg;

   localparam int PIECE_W = 3;

   typedef logic [PIECE_W-1:0] piece_t;

   localparam piece_t PIECE_NONE = 3'd7;

   // x^7 + x^6 + 1
   localparam logic [6:0] LFSR_TAPS = 7'h60;

   function automatic logic [15:0] piece_mask(input piece_t p);
      logic [15:0] m;
      m = 16'h0000;
      unique case (p)
         3'd0: m = 16'h0720;
         3'd1: m = 16'h0660;
         3'd2: m = 16'h00F0;
         3'd3: m = 16'h0360;
         3'd4: m = 16'h0630;
         3'd5: m = 16'h0740;
         3'd6: m = 16'h0E20;
         default: m = 16'h0000;
      endcase
      return m;
   endfunction

   function automatic logic [6:0] lfsr_next(input logic [6:0] s);
      return {s[5:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/next_queue_preview_module_if.sv
// Pixel-scan and piece-pop signals between the game/VGA side and
// the next-piece preview block.
interface next_queue_preview_module_if;

   logic [10:0] col_addr_sig;
   logic [10:0] row_addr_sig;
   logic        load_next_square;
   logic        preview_en;
   logic        enable_next_square;
   logic [2:0]  next_color;
   logic [2:0]  piece_out;
   logic        piece_valid;
   logic [2:0]  queue_count;

   modport master (
      output col_addr_sig,
      output row_addr_sig,
      output load_next_square,
      output preview_en,
      input  enable_next_square,
      input  next_color,
      input  piece_out,
      input  piece_valid,
      input  queue_count
   );

   modport slave (
      input  col_addr_sig,
      input  row_addr_sig,
      input  load_next_square,
      input  preview_en,
      output enable_next_square,
      output next_color,
      output piece_out,
      output piece_valid,
      output queue_count
   );

endinterface

// File: rtl/piece_queue.sv
// Random piece generator plus FIFO of upcoming pieces; entry 0 is
// the next piece handed to the game on a pop.
module piece_queue
   import tetris_pkg::*;
#(
   parameter int         DEPTH = 3,
   parameter logic [6:0] SEED  = 7'h5A
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pop_req,
   output piece_t [DEPTH-1:0]   entries,
   output logic [2:0]           count,
   output piece_t               piece_out,
   output logic                 piece_valid
);

   localparam logic [2:0] DEPTH_C = 3'(DEPTH);

   logic [6:0]         lfsr;
   piece_t             cand;
   logic               pop;
   logic               app;
   piece_t [DEPTH-1:0] q_nxt;
   logic [2:0]         cnt_nxt;

   assign cand = lfsr[2:0];
   assign pop  = pop_req && (count != 3'd0);
   assign app  = (cand != PIECE_NONE) && ((count < DEPTH_C) || pop);

   // Shift on pop first, so an append lands at the post-pop tail.
   always_comb begin
      q_nxt   = entries;
      cnt_nxt = count;
      if (pop) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            q_nxt[i] = entries[i+1];
         end
         q_nxt[DEPTH-1] = '0;
         cnt_nxt        = count - 3'd1;
      end
      if (app) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (3'(i) == cnt_nxt) begin
               q_nxt[i] = cand;
            end
         end
         cnt_nxt = cnt_nxt + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         entries     <= '0;
         count       <= 3'd0;
         lfsr        <= SEED;
         piece_out   <= '0;
         piece_valid <= 1'b0;
      end else begin
         entries     <= q_nxt;
         count       <= cnt_nxt;
         lfsr        <= lfsr_next(lfsr);
         piece_valid <= pop;
         if (pop) begin
            piece_out <= entries[0];
         end
      end
   end

endmodule

// File: rtl/next_queue_preview_module.sv
// Next-piece queue with a VGA preview: draws each queued piece in its
// own slot as 4x4 grids of CELL-pixel squares.
module next_queue_preview_module
   import tetris_pkg::*;
#(
   parameter int         DEPTH      = 3,
   parameter int         CELL       = 20,
   parameter int         ORIGIN_X   = 191,
   parameter int         ORIGIN_Y   = 51,
   parameter int         SLOT_PITCH = 100,
   parameter logic [6:0] SEED       = 7'h5A
) (
   input  logic                        clk,
   input  logic                        rst,
   next_queue_preview_module_if.slave  bus
);

   piece_t [DEPTH-1:0] entries;
   logic [2:0]         count;
   piece_t             piece_out;
   logic               piece_valid;
   logic [31:0]        cx;
   logic [31:0]        cy;
   logic [15:0]        mask;
   logic               hit;
   piece_t             color;
   logic               en_q;
   piece_t             color_q;

   piece_queue #(
      .DEPTH (DEPTH),
      .SEED  (SEED)
   ) u_queue (
      .clk         (clk),
      .rst         (rst),
      .pop_req     (bus.load_next_square),
      .entries     (entries),
      .count       (count),
      .piece_out   (piece_out),
      .piece_valid (piece_valid)
   );

   assign cx = {21'd0, bus.col_addr_sig};
   assign cy = {21'd0, bus.row_addr_sig};

   // Bounds are 32-bit, so slots past column/row 2047 never match.
   always_comb begin
      hit   = 1'b0;
      color = '0;
      mask  = 16'h0000;
      for (int k = 0; k < DEPTH; k++) begin
         mask = piece_mask(entries[k]);
         for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
               if (bus.preview_en
                   && (3'(k) < count)
                   && (cx >= 32'(ORIGIN_X + c * CELL))
                   && (cx <  32'(ORIGIN_X + (c + 1) * CELL))
                   && (cy >= 32'(ORIGIN_Y + k * SLOT_PITCH + r * CELL))
                   && (cy <  32'(ORIGIN_Y + k * SLOT_PITCH + (r + 1) * CELL))
                   && mask[4'(4 * r + c)]) begin
                  hit   = 1'b1;
                  color = entries[k];
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         en_q    <= 1'b0;
         color_q <= '0;
      end else begin
         en_q    <= hit;
         color_q <= color;
      end
   end

   assign bus.enable_next_square = en_q;
   assign bus.next_color         = color_q;
   assign bus.piece_out          = piece_out;
   assign bus.piece_valid        = piece_valid;
   assign bus.queue_count        = count;

endmodule

// File: tb/tb_next_queue_preview_module.sv
// Scoreboard bench: the driver predicts render and pop results from a
// reference queue/LFSR model; a monitor compares them a cycle later.
module tb_next_queue_preview_module;

   localparam int         DEPTH = 3;
   localparam int         CELL  = 20;
   localparam int         OX    = 191;
   localparam int         OY    = 51;
   localparam int         PITCH = 100;
   localparam logic [6:0] SEED  = 7'h5A;

   typedef struct packed {
      logic       en;
      logic [2:0] clr;
      logic       pv;
      logic [2:0] po;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   next_queue_preview_module_if bus ();

   next_queue_preview_module #(
      .DEPTH      (DEPTH),
      .CELL       (CELL),
      .ORIGIN_X   (OX),
      .ORIGIN_Y   (OY),
      .SLOT_PITCH (PITCH),
      .SEED       (SEED)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   logic [15:0] masks [7] = '{16'h0720, 16'h0660, 16'h00F0, 16'h0360,
                              16'h0630, 16'h0740, 16'h0E20};

   int vc [10] = '{211, 211, 190, 271, 191, 270, 211, 211, 250, 230};
   int vr [10] = '{71, 51, 71, 71, 51, 130, 151, 171, 251, 131};
   int sr [8]  = '{51, 71, 130, 131, 151, 191, 230, 251};

   exp_t       sq [$];
   int         mq [$];
   logic [6:0] m_lfsr;
   logic [2:0] m_pout;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void render_exp(input int col, input int row,
                                      input int pen, output logic en,
                                      output logic [2:0] clr);
      int c, r, k, off;
      logic [15:0] m;
      en  = 1'b0;
      clr = 3'd0;
      if (pen == 0 || col < OX || col >= OX + 4 * CELL || row < OY) return;
      c   = (col - OX) / CELL;
      k   = (row - OY) / PITCH;
      off = (row - OY) % PITCH;
      if (off >= 4 * CELL || k >= mq.size()) return;
      r = off / CELL;
      m = masks[mq[k]];
      if (((m >> (4 * r + c)) & 16'd1) != 16'd0) begin
         en  = 1'b1;
         clr = 3'(mq[k]);
      end
   endfunction

   task automatic model_reset();
      mq.delete();
      sq.delete();
      m_lfsr = SEED;
      m_pout = 3'd0;
   endtask

   task automatic step(input int col, input int row, input int ld,
                       input int pen);
      exp_t       e;
      logic       en;
      logic [2:0] clr;
      int         cand;
      int         sz;
      bit         popped;
      bus.col_addr_sig     = 11'(col);
      bus.row_addr_sig     = 11'(row);
      bus.load_next_square = (ld != 0);
      bus.preview_en       = (pen != 0);
      chk("queue_count", int'(bus.queue_count), mq.size());
      render_exp(col, row, pen, en, clr);
      sz     = mq.size();
      popped = (ld != 0) && (sz != 0);
      if (popped) m_pout = 3'(mq[0]);
      e = '{en, clr, popped, m_pout};
      sq.push_back(e);
      if (popped) void'(mq.pop_front());
      cand = int'(m_lfsr[2:0]);
      if (cand != 7 && (sz < DEPTH || popped)) mq.push_back(cand);
      m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_en"}, int'(bus.enable_next_square), 0);
      chk({tag, "_color"}, int'(bus.next_color), 0);
      chk({tag, "_piece_out"}, int'(bus.piece_out), 0);
      chk({tag, "_piece_valid"}, int'(bus.piece_valid), 0);
      chk({tag, "_count"}, int'(bus.queue_count), 0);
   endtask

   initial begin
      forever begin
         exp_t e;
         @(posedge clk);
         if (sq.size() != 0) begin
            e = sq.pop_front();
            @(negedge clk);
            if (!rst) begin
               chk("enable_next_square", int'(bus.enable_next_square),
                   int'(e.en));
               chk("next_color", int'(bus.next_color), int'(e.clr));
               chk("piece_valid", int'(bus.piece_valid), int'(e.pv));
               chk("piece_out", int'(bus.piece_out), int'(e.po));
            end
         end
      end
   end

   initial begin
      rst                  = 1'b1;
      bus.col_addr_sig     = 11'd0;
      bus.row_addr_sig     = 11'd0;
      bus.load_next_square = 1'b0;
      bus.preview_en       = 1'b0;
      @(posedge clk);
      #1;
      chk_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();

      step(211, 71, 1, 1);
      repeat (6) step(0, 0, 0, 1);
      for (int i = 0; i < 10; i++) step(vc[i], vr[i], 0, 1);
      step(211, 71, 1, 1);
      step(211, 71, 0, 1);
      for (int i = 0; i < 8; i++) begin
         for (int cc = 185; cc < 280; cc += 10) step(cc, sr[i], 0, 1);
      end
      for (int i = 0; i < 5; i++) step(211, 71 + 100 * (i % 3), 1, 1);
      repeat (3) step(0, 0, 0, 1);
      step(211, 71, 0, 0);
      step(231, 171, 0, 0);
      for (int i = 0; i < 10; i++) step(vc[i], vr[i], 0, 1);
      repeat (4) step(211, 71, 0, 1);

      step(211, 71, 1, 1);
      #2;
      rst = 1'b1;
      sq.delete();
      #1;
      chk_zero("async_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      repeat (6) step(211, 71, 0, 1);
      for (int i = 0; i < 10; i++) step(vc[i], vr[i], i % 2, 1);
      repeat (3) step(251, 131, 0, 1);

      @(posedge clk);
      @(negedge clk);
      #1;
      chk("scoreboard_drain", sq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/next_queue_preview_module.md
NEXT_QUEUE_PREVIEW_MODULE -- requirements
Module: next_queue_preview_module

Interface
REQ-001 Parameter DEPTH, default 3, number of queued preview pieces (legal 1..4).
REQ-002 Parameter CELL, default 20, cell edge in pixels (legal 2..32).
REQ-003 Parameter ORIGIN_X, default 191, first pixel column of every preview slot.
REQ-004 Parameter ORIGIN_Y, default 51, first pixel row of slot 0.
REQ-005 Parameter SLOT_PITCH, default 100, row offset between slot k and slot k+1 (must be >= 4*CELL).
REQ-006 Parameter SEED, default 7'h5A, LFSR reset value (nonzero).
REQ-007 clk  input  1  system clock; the block has one clock; all state changes on its rising edge.
REQ-008 rst  input  1  asynchronous, active-high reset.
REQ-009 col_addr_sig  input  11  current VGA pixel column.
REQ-010 row_addr_sig  input  11  current VGA pixel row.
REQ-011 load_next_square  input  1  single-cycle pop request from the game controller.
REQ-012 preview_en  input  1  1 = draw preview, 0 = blank the render outputs.
REQ-013 enable_next_square  output  1  current pixel lies in a filled cell of any queued piece.
REQ-014 next_color  output  3  piece type of the slot being drawn; 0 when enable_next_square is 0.
REQ-015 piece_out  output  3  type handed to the game on the last accepted pop.
REQ-016 piece_valid  output  1  one-cycle pulse marking piece_out update.
REQ-017 queue_count  output  3  number of valid queue entries (0..DEPTH).

Function
REQ-018 Piece types 0..6 SHALL use fixed 16-bit masks, bit 4r+c = row r, column c: 0=16'h0720 T, 1=16'h0660 O, 2=16'h00F0 I, 3=16'h0360 S, 4=16'h0630 Z, 5=16'h0740 L, 6=16'h0E20 J.
REQ-019 A 7-bit Fibonacci LFSR (taps x^7+x^6+1) SHALL advance every cycle out of reset; candidate = lfsr[2:0]; candidate 7 is rejected that cycle.
REQ-020 Generation SHALL append the candidate at queue tail in a cycle when the candidate is not 7 and (queue_count < DEPTH or a pop is accepted that cycle).
REQ-021 A pop SHALL be accepted when load_next_square=1 and queue_count != 0; a pop with queue_count=0 SHALL be ignored, with no piece_valid pulse.
REQ-022 On an accepted pop, piece_out SHALL take entry 0 and piece_valid SHALL be 1 on the following cycle only; entries 1..DEPTH-1 shift down by one.
REQ-023 Simultaneous pop and append SHALL leave queue_count unchanged, with the new piece in entry queue_count-1.
REQ-024 Pop without append SHALL decrement queue_count; append without pop SHALL increment it; count SHALL never exceed DEPTH.
REQ-025 Slot k (0..DEPTH-1) SHALL display entry k; pixel in cell (r,c) of slot k iff ORIGIN_X+c*CELL <= col <= ORIGIN_X+c*CELL+CELL-1 and ORIGIN_Y+k*SLOT_PITCH+r*CELL <= row <= ORIGIN_Y+k*SLOT_PITCH+r*CELL+CELL-1.
REQ-026 enable_next_square SHALL be 1 iff preview_en=1, the pixel lies in cell (r,c) of slot k with k < queue_count, and mask bit 4r+c of entry k is 1.
REQ-027 enable_next_square and next_color SHALL be registered, with latency exactly 1 cycle from col_addr_sig/row_addr_sig/preview_en.
REQ-028 Render SHALL use queue contents as registered at the start of the cycle; a pop mid-frame SHALL take effect on the next pixel.
REQ-029 All coordinate comparisons SHALL be unsigned 11-bit; slot bounds exceeding 2047 SHALL never match.

Reset
REQ-030 On rst: queue empty, queue_count=0, lfsr=SEED, piece_out=0, piece_valid=0, enable_next_square=0, next_color=0.
REQ-031 Reset asserted mid-operation SHALL clear all state immediately, without waiting for a clock edge; after release the queue refills from SEED, deterministically.

Structure
REQ-032 Mask table, piece type width (3), and LFSR tap constant SHALL reside in shared package tetris_pkg.
REQ-033 Generator plus queue SHALL be sub-module piece_queue; rendering SHALL stay in the top module.

Verification
REQ-034 Reset release with defaults -> queue_count reaches 3 within 3 cycles plus one cycle per rejected candidate; sequence matches a reference LFSR model from SEED 7'h5A.
REQ-035 Queue full, pop pulse -> piece_valid 1 for exactly one cycle, piece_out = old entry 0, queue_count stays 3 or recovers to 3 next valid candidate.
REQ-036 Force entry 0 = type 2 (I), col=211,row=71 -> enable_next_square=1, next_color=2 one cycle later; col=211,row=51 -> 0.
REQ-037 Pixel col=190 or col=271 at any row -> enable_next_square=0; slot 1 row 151..230 draws entry 1.
REQ-038 Pops on consecutive cycles from count 3 with LFSR stalled on candidate 7 -> count 3,2,1,0; fourth pop ignored, no pulse.
REQ-039 rst asserted between clock edges while queue full -> all outputs 0 immediately; preview_en=0 at any time -> enable_next_square=0 one cycle later.
